// File: rtl/p20_game_pkg.sv
// p20_game_pkg: shared widths, spawner states and cactus kinds for the dino obstacle logic
package p20_game_pkg;
  localparam int X_W = 10;
  typedef enum logic [1:0] {STOPPED, COUNT, PENDING} spawn_state_e;
  typedef enum logic [1:0] {KIND_SMALL, KIND_TALL, KIND_DOUBLE, KIND_TRIPLE} cactus_kind_e;
endpackage

// File: rtl/p20_obstacle_slot.sv
// p20_obstacle_slot: one obstacle slot that loads at the spawn point, scrolls left and expires
module p20_obstacle_slot #(
  parameter int X_W = p20_game_pkg::X_W,
  parameter int SPAWN_X = 640
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           load,
  input  logic [1:0]     load_kind,
  input  logic           scroll,
  input  logic [2:0]     speed,
  output logic           valid,
  output logic [X_W-1:0] x,
  output logic [1:0]     kind
);
  import p20_game_pkg::*;
  logic           valid_q, valid_d;
  logic [X_W-1:0] x_q, x_d;
  cactus_kind_e   kind_q, kind_d;
  logic           expire;
  assign expire = x_q < X_W'(speed);
  // a freshly loaded slot is not scrolled on the same tick
  always_comb begin
    valid_d = valid_q;
    x_d = x_q;
    kind_d = kind_q;
    if (clear) begin
      valid_d = 1'b0;
      x_d = '0;
      kind_d = KIND_SMALL;
    end else if (load) begin
      valid_d = 1'b1;
      x_d = X_W'(SPAWN_X);
      kind_d = cactus_kind_e'(load_kind);
    end else if (scroll && valid_q) begin
      valid_d = !expire;
      x_d = expire ? x_q : x_q - X_W'(speed);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      x_q <= '0;
      kind_q <= KIND_SMALL;
    end else begin
      valid_q <= valid_d;
      x_q <= x_d;
      kind_q <= kind_d;
    end
  assign valid = valid_q;
  assign x = x_q;
  assign kind = kind_q;
endmodule

// File: rtl/p20_cactus_spawner.sv
// p20_cactus_spawner: times cactus spawns from the LFSR and scrolls two obstacle slots per frame
module p20_cactus_spawner #(
  parameter int X_W = p20_game_pkg::X_W,
  parameter int SPAWN_X = 640,
  parameter int MIN_GAP = 16
) (
  input  logic           clk,
  input  logic           sys_rst_n,
  input  logic           run,
  input  logic           clear,
  input  logic           tick,
  input  logic [2:0]     speed,
  input  logic [4:0]     rng,
  output logic           rng_advance,
  output logic           spawn_pulse,
  output logic [1:0]     obs_valid,
  output logic [X_W-1:0] obs_x0,
  output logic [X_W-1:0] obs_x1,
  output logic [1:0]     obs_kind0,
  output logic [1:0]     obs_kind1
);
  import p20_game_pkg::*;
  spawn_state_e state_q, state_d;
  logic [5:0]   gap_q, gap_d;
  logic         adv_q, pulse_q;
  logic         act, due, spawn;
  logic [1:0]   free, load;
  assign act = run && tick && !clear;
  assign free = ~obs_valid;
  assign due = act && ((state_q == COUNT && gap_q == 6'd1) || state_q == PENDING);
  assign spawn = due && |free;
  // slot choice uses occupancy before this tick's scroll
  assign load = {spawn && !free[0] && free[1], spawn && free[0]};
  always_comb begin
    state_d = state_q;
    gap_d = gap_q;
    if (clear) begin
      state_d = STOPPED;
      gap_d = 6'(MIN_GAP);
    end else if (state_q == STOPPED) begin
      state_d = run ? COUNT : STOPPED;
      gap_d = 6'(MIN_GAP);
    end else if (spawn) begin
      state_d = COUNT;
      gap_d = 6'(MIN_GAP) + {1'b0, rng[4:2], 2'b00};
    end else if (due) begin
      state_d = PENDING;
    end else if (act && state_q == COUNT) begin
      gap_d = gap_q - 6'd1;
    end
  end
  always_ff @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= STOPPED;
      gap_q <= 6'(MIN_GAP);
      adv_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q <= gap_d;
      adv_q <= spawn;
      pulse_q <= spawn;
    end
  assign rng_advance = adv_q;
  assign spawn_pulse = pulse_q;
  p20_obstacle_slot #(.X_W(X_W), .SPAWN_X(SPAWN_X)) u_slot0 (
    .clk(clk), .rst_n(sys_rst_n), .clear(clear), .load(load[0]), .load_kind(rng[1:0]),
    .scroll(act), .speed(speed), .valid(obs_valid[0]), .x(obs_x0), .kind(obs_kind0)
  );
  p20_obstacle_slot #(.X_W(X_W), .SPAWN_X(SPAWN_X)) u_slot1 (
    .clk(clk), .rst_n(sys_rst_n), .clear(clear), .load(load[1]), .load_kind(rng[1:0]),
    .scroll(act), .speed(speed), .valid(obs_valid[1]), .x(obs_x1), .kind(obs_kind1)
  );
endmodule

// File: tb/tb_p20_cactus_spawner.sv
// tb_p20_cactus_spawner: directed stimulus with a behavioural spawner model checked every cycle
module tb_p20_cactus_spawner;
  localparam int MIN_GAP = 16;
  localparam int SPAWN_X = 640;
  logic       clk, sys_rst_n, run, clear, tick;
  logic [2:0] speed;
  logic [4:0] rng;
  logic       rng_advance, spawn_pulse;
  logic [1:0] obs_valid, obs_kind0, obs_kind1;
  logic [9:0] obs_x0, obs_x1;
  int checks = 0;
  int errors = 0;
  bit mv[2];
  int mx[2];
  int mk[2];
  int gap;
  bit started, waiting, m_adv;

  p20_cactus_spawner dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .run(run), .clear(clear), .tick(tick),
    .speed(speed), .rng(rng), .rng_advance(rng_advance), .spawn_pulse(spawn_pulse),
    .obs_valid(obs_valid), .obs_x0(obs_x0), .obs_x1(obs_x1),
    .obs_kind0(obs_kind0), .obs_kind1(obs_kind1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0;
      mx[i] = 0;
      mk[i] = 0;
    end
    gap = MIN_GAP;
    started = 1'b0;
    waiting = 1'b0;
    m_adv = 1'b0;
  endtask

  // Game rules: a due spawn takes the lowest slot empty before the scroll; others scroll or fall off
  task automatic model_step();
    int slot;
    bit due;
    m_adv = 1'b0;
    if (clear) model_reset();
    else if (run) begin
      if (!started) begin
        started = 1'b1;
        gap = MIN_GAP;
      end else if (tick) begin
        slot = -1;
        due = waiting || gap == 1;
        if (due) for (int i = 1; i >= 0; i--) if (!mv[i]) slot = i;
        for (int i = 0; i < 2; i++)
          if (mv[i] && i != slot) begin
            if (mx[i] < int'(speed)) mv[i] = 1'b0;
            else mx[i] = mx[i] - int'(speed);
          end
        if (!due) gap = gap - 1;
        else if (slot < 0) waiting = 1'b1;
        else begin
          mv[slot] = 1'b1;
          mx[slot] = SPAWN_X;
          mk[slot] = int'(rng[1:0]);
          gap = MIN_GAP + 4 * int'(rng[4:2]);
          waiting = 1'b0;
          m_adv = 1'b1;
        end
      end
    end
  endtask

  initial model_reset();
  always @(negedge sys_rst_n) model_reset();
  always @(posedge clk) if (sys_rst_n) model_step();

  always @(negedge clk) begin
    cmp("m_valid", obs_valid, {mv[1], mv[0]});
    if (mv[0]) begin
      cmp("m_x0", obs_x0, mx[0]);
      cmp("m_kind0", obs_kind0, mk[0]);
    end
    if (mv[1]) begin
      cmp("m_x1", obs_x1, mx[1]);
      cmp("m_kind1", obs_kind1, mk[1]);
    end
    cmp("m_spawn_pulse", spawn_pulse, m_adv);
    cmp("m_rng_advance", rng_advance, m_adv);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tk1();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic tk(input int n);
    repeat (n) begin
      tk1();
      step(3);
    end
  endtask

  task automatic restart(input logic [4:0] r);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    rng = r;
    step(1);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    run = 1'b0;
    clear = 1'b0;
    tick = 1'b0;
    speed = 3'd2;
    rng = 5'b10110;
    step(2);
    cmp("rst_valid", obs_valid, 0);
    cmp("rst_x0", obs_x0, 0);
    cmp("rst_adv", rng_advance, 0);
    cmp("rst_pulse", spawn_pulse, 0);
    sys_rst_n = 1'b1;
    run = 1'b1;
    step(1);
    tk(15);
    cmp("pre_spawn_valid", obs_valid, 0);
    tk1();
    cmp("t16_valid", obs_valid, 1);
    cmp("t16_x0", obs_x0, 640);
    cmp("t16_kind0", obs_kind0, 2);
    cmp("t16_adv", rng_advance, 1);
    cmp("t16_pulse", spawn_pulse, 1);
    step(1);
    cmp("t16_adv_drop", rng_advance, 0);
    step(2);
    run = 1'b0;
    tk(10);
    cmp("frozen_valid", obs_valid, 1);
    cmp("frozen_x0", obs_x0, 640);
    run = 1'b1;
    tk(25);
    speed = 3'd0;
    tk(10);
    cmp("gap35_valid", obs_valid, 1);
    cmp("gap35_x0", obs_x0, 590);
    tk1();
    cmp("gap36_valid", obs_valid, 3);
    cmp("gap36_x1", obs_x1, 640);
    cmp("gap36_kind1", obs_kind1, 2);
    cmp("gap36_x0", obs_x0, 590);
    step(3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    cmp("arst_valid", obs_valid, 0);
    cmp("arst_x0", obs_x0, 0);
    cmp("arst_x1", obs_x1, 0);
    cmp("arst_kind1", obs_kind1, 0);
    @(posedge clk);
    #1;
    sys_rst_n = 1'b1;
    speed = 3'd2;
    step(1);
    tk(15);
    clear = 1'b1;
    tk1();
    clear = 1'b0;
    cmp("clr_valid", obs_valid, 0);
    cmp("clr_pulse", spawn_pulse, 0);
    cmp("clr_adv", rng_advance, 0);
    step(3);
    tk(15);
    cmp("clr_t15_valid", obs_valid, 0);
    tk1();
    cmp("clr_t16_valid", obs_valid, 1);
    cmp("clr_t16_x0", obs_x0, 640);
    cmp("clr_t16_adv", rng_advance, 1);
    step(3);
    restart(5'b11100);
    tk(15);
    tk1();
    cmp("b_spawn_kind0", obs_kind0, 0);
    speed = 3'd7;
    step(3);
    tk(43);
    tk1();
    cmp("b_k44_valid", obs_valid, 3);
    cmp("b_k44_x0", obs_x0, 332);
    cmp("b_k44_x1", obs_x1, 640);
    step(3);
    tk(43);
    tk1();
    cmp("b_full_valid", obs_valid, 3);
    cmp("b_full_adv", rng_advance, 0);
    step(3);
    tk(3);
    cmp("b_x0_is3", obs_x0, 3);
    speed = 3'd4;
    tk1();
    cmp("b_expire_valid", obs_valid, 2);
    cmp("b_expire_adv", rng_advance, 0);
    step(3);
    tk1();
    cmp("b_retry_valid", obs_valid, 3);
    cmp("b_retry_x0", obs_x0, 640);
    cmp("b_retry_adv", rng_advance, 1);
    step(3);
    restart(5'b11100);
    tk(16);
    speed = 3'd6;
    tk(106);
    cmp("c_x0_is4", obs_x0, 4);
    speed = 3'd4;
    tk1();
    cmp("c_zero_valid", obs_valid, 3);
    cmp("c_zero_x0", obs_x0, 0);
    step(3);
    tk1();
    cmp("c_gone_valid", obs_valid, 2);
    cmp("c_gone_adv", rng_advance, 0);
    step(3);
    tk1();
    cmp("c_respawn_valid", obs_valid, 3);
    cmp("c_respawn_x0", obs_x0, 640);
    step(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/p20_cactus_spawner.md
# p20_cactus_spawner

Obstacle spawner for the dino game. Consumes the 5-bit cactus LFSR value, decides when and what kind of cactus to spawn, and scrolls up to two live obstacles leftward once per frame tick. It drives the LFSR's advance strobe, so each spawn pulls a fresh random value. Its slot outputs feed the renderer and the collision checker.

## Interface
Parameters:
- X_W, 10, width of horizontal position
- SPAWN_X, 640, x position loaded into a newly spawned obstacle
- MIN_GAP, 16, minimum ticks between spawns; legal range 1..35

Ports:
- clk  in  1  system clock
- sys_rst_n  in  1  asynchronous, active-low reset
- run  in  1  game running; 0 freezes all state
- clear  in  1  synchronous restart; empties slots
- tick  in  1  one-cycle frame strobe
- speed  in  3  pixels scrolled per tick; 0 is legal
- rng  in  5  current LFSR value
- rng_advance  out  1  one-cycle pulse to LFSR entropy_in
- spawn_pulse  out  1  one-cycle pulse when a spawn occurs
- obs_valid  out  2  per-slot occupied flag
- obs_x0, obs_x1  out  X_W  slot positions
- obs_kind0, obs_kind1  out  2  slot cactus kind

## Operation
- FSM states:
  - STOPPED: entered on reset or clear. Next cycle with run=1 goes to COUNT and loads gap_cnt=MIN_GAP.
  - COUNT: on each tick with gap_cnt==1, try to spawn; otherwise decrement gap_cnt.
  - PENDING: the countdown expired but no slot was free; retry on every tick.
- Spawn rule:
  - A spawn uses the lowest-index slot that is free before this tick's scroll.
  - A slot freed by this tick's scroll cannot be used until the next tick.
  - On success: slot x=SPAWN_X and kind=rng[1:0].
  - The gap reloads to gap_cnt = MIN_GAP + 4*rng[4:2], giving MIN_GAP..MIN_GAP+28 in a 6-bit counter.
  - After a successful spawn the FSM is in COUNT.
  - On failure the FSM goes to PENDING.
- Scroll on tick, per valid slot that was not spawned this tick:
  - x < speed: slot becomes invalid.
  - Otherwise: x ← x − speed. x==speed yields x=0, still valid.
  - No wrap-around and no underflow are possible.
- run=0:
  - tick is ignored: no scroll, no countdown, no spawn.
  - All registers hold, FSM included (except in STOPPED, which stays STOPPED).
- Priority:
  - clear has priority over tick and run.
  - On clear: obs_valid=0, x and kind cleared to 0, gap_cnt=MIN_GAP, FSM=STOPPED, and any pending rng_advance is suppressed.
- Reset values: every output is 0, FSM=STOPPED, gap_cnt=MIN_GAP.

## Timing
- All outputs are registered.
- Tick at edge N (tick sampled high at the rising edge N):
  - Slot updates and spawn_pulse are visible after edge N.
  - rng_advance is high during the cycle between edges N and N+1 only.
  - The LFSR steps at edge N+1, so the new rng value is valid from N+1.
- Consecutive ticks must be ≥3 cycles apart. This guarantees the next spawn samples a fresh rng.
- Exactly one rng_advance per spawn. None on a failed spawn, a scroll, or a clear.
- Asynchronous reset mid-operation clears everything immediately. Operation restarts through STOPPED.

## Structure
- Shared package p20_game_pkg holds:
  - X_W
  - the FSM state enum (STOPPED, COUNT, PENDING)
  - the cactus kind encoding: 0 small, 1 tall, 2 double, 3 triple
- Sub-module p20_obstacle_slot, instantiated twice. It holds valid/x/kind and implements the scroll/expire rule, plus a load port for spawning.
- The top level holds the FSM, gap_cnt, slot selection and the rng_advance register.

## Test plan
- Reset, run=1, speed=2, tick every 4 cycles, rng=5'b10110 → spawn on the 16th tick into slot 0 with x=640, kind=2. rng_advance is high for exactly one cycle after that tick. The next spawn comes 36 ticks later into slot 1.
- Slot at x=3, speed=4, tick → obs_valid bit drops. Slot at x=4, speed=4 → x=0 and the slot stays valid; the next tick invalidates it.
- Both slots full when gap_cnt==1 on a tick → FSM=PENDING with no rng_advance. On the tick after a slot expires, spawn into that slot (x=640) and the FSM returns to COUNT.
- run=0 across 10 ticks → positions, gap_cnt and FSM unchanged. speed=0 with run=1 → positions unchanged while the countdown still advances.
- clear asserted together with a tick that would spawn → no spawn and no rng_advance; slots empty, FSM=STOPPED, and the restart spawns 16 ticks later.
- sys_rst_n pulsed low mid-cycle with two live slots → all outputs 0 immediately, without waiting for a clock edge.
